// File: rtl/div32_16_seq.sv
// Sequential restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor, one quotient bit per clock.
// Divide-by-zero and quotient overflow are detected at accept and finish in a single cycle.
module div32_16_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_by_zero,
  output logic                 overflow,
  output logic                 busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   rem_r;
  logic [WIDTH-1:0]   quo_r;
  logic [WIDTH-1:0]   dsr_r;

  logic [WIDTH:0]     shifted;
  logic               fits;
  logic [WIDTH-1:0]   rem_nx;
  logic [WIDTH-1:0]   quo_nx;

  logic               accept;
  logic               is_zero;
  logic               is_ovf;

  // Trial subtraction; only called when the result is known nonnegative and below the divisor.
  function automatic logic [WIDTH-1:0] restore_sub(input logic [WIDTH:0] a,
                                                   input logic [WIDTH-1:0] b);
    return WIDTH'(a - {1'b0, b});
  endfunction

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  assign accept  = in_valid && (state == IDLE);
  assign is_zero = (divisor == '0);
  assign is_ovf  = (dividend[2*WIDTH-1:WIDTH] >= divisor);

  // Partial remainder stays below the divisor, so it fits WIDTH bits between steps.
  always_comb begin
    shifted = {rem_r, quo_r[WIDTH-1]};
    fits    = (shifted >= {1'b0, dsr_r});
    rem_nx  = fits ? restore_sub(shifted, dsr_r) : shifted[WIDTH-1:0];
    quo_nx  = {quo_r[WIDTH-2:0], fits};
  end

  // Control and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_zero) begin
              quotient    <= '1;
              remainder   <= dividend[WIDTH-1:0];
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
              state       <= DONE;
            end else if (is_ovf) begin
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b0;
              overflow    <= 1'b1;
              state       <= DONE;
            end else begin
              cnt   <= CNT_W'(WIDTH);
              state <= RUN;
            end
          end
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            quotient    <= quo_nx;
            remainder   <= rem_nx;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Iteration datapath
  always_ff @(posedge clk) begin
    if (accept) begin
      rem_r <= dividend[2*WIDTH-1:WIDTH];
      quo_r <= dividend[WIDTH-1:0];
      dsr_r <= divisor;
    end else if (state == RUN) begin
      rem_r <= rem_nx;
      quo_r <= quo_nx;
    end
  end

endmodule

// File: tb/tb_div32_16_seq.sv
// Directed bench for div32_16_seq: hand-computed vectors, exceptions, backpressure,
// asynchronous reset mid-operation and a short reference-checked sweep.
module tb_div32_16_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        overflow;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  div32_16_seq #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands for one edge; returns after the accept edge (+1).
  task automatic launch(input logic [31:0] dvd, input logic [15:0] dsr);
    @(negedge clk);
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    dividend = dvd;
    divisor  = dsr;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 16'h5A5A;
  endtask

  // Count edges after accept until out_valid, bounded.
  task automatic wait_done(input string tag, input int exp_lat);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_latency"}, cyc, exp_lat);
  endtask

  task automatic do_op(input string tag, input logic [31:0] dvd, input logic [15:0] dsr,
                       input logic [15:0] eq, input logic [15:0] er,
                       input logic edz, input logic eov, input int lat);
    out_ready = 1'b1;
    launch(dvd, dsr);
    wait_done(tag, lat);
    check({tag, "_quotient"},  {16'd0, quotient},  {16'd0, eq});
    check({tag, "_remainder"}, {16'd0, remainder}, {16'd0, er});
    check({tag, "_flags"},     {30'd0, div_by_zero, overflow}, {30'd0, edz, eov});
    @(posedge clk);
    #1;
    check({tag, "_retired"}, {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
  endtask

  initial begin
    logic [31:0] dvd;
    logic [15:0] dsr;
    logic [15:0] hi;
    logic [31:0] eq;
    logic [31:0] er;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {28'd0, in_ready, out_valid, busy, div_by_zero}, {28'd0, 4'b1000});
    check("reset_ovf", {31'd0, overflow}, 32'd0);
    check("reset_result", {quotient, remainder}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("div200_10", 32'h0000_00C8, 16'h000A, 16'h0014, 16'h0000, 1'b0, 1'b0, 16);
    do_op("div1234",   32'h1234_5678, 16'h4321, 16'h456C, 16'h1F8C, 1'b0, 1'b0, 16);
    do_op("divmax",    32'hFFFE_0001, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 16);
    do_op("ovf",       32'h0001_0000, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 0);
    do_op("dbz",       32'hABCD_1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 0);

    // Backpressure: hold result while out_ready low, ignore new requests.
    out_ready = 1'b0;
    launch(32'h0000_03E8, 16'h0021);
    wait_done("bp", 16);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      dividend = 32'h0000_0005;
      divisor  = 16'h0000;
      @(posedge clk);
      #1;
      check("bp_hold_q",  {quotient, remainder}, {16'h001E, 16'h000A});
      check("bp_hold_ctl", {28'd0, out_valid, in_ready, busy, div_by_zero}, {28'd0, 4'b1010});
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_retire", {30'd0, out_valid, in_ready}, {30'd0, 2'b01});
    do_op("bp_next", 32'h0000_0051, 16'h0009, 16'h0009, 16'h0000, 1'b0, 1'b0, 16);

    // Asynchronous reset in the middle of an iteration run.
    launch(32'h0000_00C8, 16'h000A);
    repeat (8) @(posedge clk);
    #2;
    check("mid_run_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async_ctl", {28'd0, in_ready, out_valid, busy, overflow}, {28'd0, 4'b1000});
    check("rst_async_res", {quotient, remainder}, 32'd0);
    check("rst_async_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (20) begin
        @(posedge clk);
        #1;
        if (out_valid) seen++;
      end
      check("rst_no_valid", seen, 0);
    end
    do_op("after_rst", 32'h0000_0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 1'b0, 16);

    // Back-to-back sweep against the integer reference.
    for (int k = 0; k < 200; k++) begin
      dsr = 16'($urandom_range(1, 65535));
      hi  = 16'($urandom_range(0, int'(dsr) - 1));
      dvd = {hi, 16'($urandom)};
      eq  = dvd / {16'd0, dsr};
      er  = dvd % {16'd0, dsr};
      do_op("sweep", dvd, dsr, eq[15:0], er[15:0], 1'b0, 1'b0, 16);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
